// File: rtl/macc_pkg.sv
// Shared types and Q-format helpers for the arbitrated MACC.
// The stage record is sized for the widest supported word. Each user slices it down to WIDTH.
package macc_pkg;

    localparam int MAX_WIDTH = 32;
    localparam int MAX_ID_W  = 3;
    localparam int WIDE_W    = 2 * MAX_WIDTH + 1;

    typedef logic signed [MAX_WIDTH-1:0] word_t;
    typedef logic signed [WIDE_W-1:0]    wide_t;

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
        word_t               y;
        logic                sat;
    } stage_t;

    // Largest value representable in a signed word of the given width.
    function automatic wide_t sat_max(input int unsigned width);
        wide_t one;
        one = wide_t'(1);
        return (one <<< (width - 1)) - one;
    endfunction

    // Smallest value representable in a signed word of the given width.
    function automatic wide_t sat_min(input int unsigned width);
        wide_t one;
        one = wide_t'(1);
        return -(one <<< (width - 1));
    endfunction

endpackage

// File: rtl/macc_pipe.sv
// Shared multiply-accumulate pipeline: y = sat((m*x) >>> FRAC + b).
// Each stage holds {valid, id, y, sat}. The whole pipe moves only when advance is high.
module macc_pipe
    import macc_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int FRAC     = 8,
    parameter int MACC_LAT = 2,
    parameter int ID_W     = 2
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic signed [WIDTH-1:0] m_in,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] b_in,
    input  logic                    in_valid,
    input  logic [ID_W-1:0]         in_id,
    input  logic                    advance,
    output logic signed [WIDTH-1:0] y_out,
    output logic                    sat_out,
    output logic                    out_valid,
    output logic [ID_W-1:0]         out_id
);

    typedef logic signed [2*WIDTH-1:0] prod_t;

    // Arithmetic shift of a signed value rounds toward minus infinity.
    function automatic wide_t floor_shift(input prod_t p);
        return wide_t'(p >>> FRAC);
    endfunction

    // Returns {clamped, y}.
    function automatic logic [WIDTH:0] saturate(input wide_t s);
        wide_t hi;
        wide_t lo;
        hi = sat_max(WIDTH);
        lo = sat_min(WIDTH);
        if (s > hi) begin
            return {1'b1, WIDTH'(hi)};
        end else if (s < lo) begin
            return {1'b1, WIDTH'(lo)};
        end
        return {1'b0, WIDTH'(s)};
    endfunction

    prod_t          prod_p0;
    wide_t          sum_p0;
    logic [WIDTH:0] sat_res_p0;
    stage_t         entry_p0;

    stage_t stage_q [MACC_LAT];
    stage_t stage_d [MACC_LAT];

    // Stage 0 (combinational): full product, floor shift, add, clamp.
    always_comb begin
        prod_p0    = prod_t'(m_in) * prod_t'(x_in);
        sum_p0     = floor_shift(prod_p0) + wide_t'(b_in);
        sat_res_p0 = saturate(sum_p0);
        entry_p0   = '0;
        if (in_valid) begin
            entry_p0.valid         = 1'b1;
            entry_p0.id[ID_W-1:0]  = in_id;
            entry_p0.y             = word_t'(signed'(sat_res_p0[WIDTH-1:0]));
            entry_p0.sat           = sat_res_p0[WIDTH];
        end
    end

    // Stages 1..MACC_LAT: move as one unit, or hold as one unit.
    always_comb begin
        for (int k = 0; k < MACC_LAT; k++) begin
            stage_d[k] = stage_q[k];
        end
        if (advance) begin
            stage_d[0] = entry_p0;
            for (int k = 1; k < MACC_LAT; k++) begin
                stage_d[k] = stage_q[k-1];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int k = 0; k < MACC_LAT; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < MACC_LAT; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign out_valid = stage_q[MACC_LAT-1].valid;
    assign out_id    = stage_q[MACC_LAT-1].id[ID_W-1:0];
    assign y_out     = stage_q[MACC_LAT-1].y[WIDTH-1:0];
    assign sat_out   = stage_q[MACC_LAT-1].sat;

    logic unused_stage_bits;
    assign unused_stage_bits = ^stage_q[MACC_LAT-1];

endmodule

// File: rtl/macc_arbiter.sv
// Round-robin arbiter in front of a single shared MACC pipeline.
// Holds only the grant logic, the handshake and the last_grant state. All arithmetic is in macc_pipe.
module macc_arbiter
    import macc_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 16,
    parameter int FRAC     = 8,
    parameter int MACC_LAT = 2
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [N_REQ-1:0]               req_valid_in,
    output logic [N_REQ-1:0]               req_ready_out,
    input  logic [N_REQ-1:0][WIDTH-1:0]    req_m_in,
    input  logic [N_REQ-1:0][WIDTH-1:0]    req_x_in,
    input  logic [N_REQ-1:0][WIDTH-1:0]    req_b_in,
    output logic                           out_valid_out,
    input  logic                           out_ready_in,
    output logic [WIDTH-1:0]               out_y_out,
    output logic [$clog2(N_REQ)-1:0]       out_id_out,
    output logic                           out_sat_out
);

    localparam int ID_W = $clog2(N_REQ);

    logic [ID_W-1:0] last_grant_q;
    logic [ID_W-1:0] last_grant_d;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] grant_id;
    logic            grant_found;
    logic            advance;
    logic            accept;

    logic signed [WIDTH-1:0] sel_m;
    logic signed [WIDTH-1:0] sel_x;
    logic signed [WIDTH-1:0] sel_b;
    logic signed [WIDTH-1:0] pipe_y;
    logic                    pipe_sat;
    logic                    pipe_valid;
    logic [ID_W-1:0]         pipe_id;

    // An empty final stage always lets the pipe move, so bubbles collapse.
    assign advance = !pipe_valid || out_ready_in;

    // Search from the requester after the last winner, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(last_grant_q) + k) % N_REQ);
            if (!grant_found && req_valid_in[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    always_comb begin
        req_ready_out = '0;
        if (!rst_in && advance && grant_found) begin
            req_ready_out[grant_id] = 1'b1;
        end
    end

    assign accept = |req_ready_out;

    always_comb begin
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = grant_id;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            last_grant_q <= ID_W'(N_REQ - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign sel_m = req_m_in[grant_id];
    assign sel_x = req_x_in[grant_id];
    assign sel_b = req_b_in[grant_id];

    macc_pipe #(
        .WIDTH    (WIDTH),
        .FRAC     (FRAC),
        .MACC_LAT (MACC_LAT),
        .ID_W     (ID_W)
    ) u_pipe (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .m_in      (sel_m),
        .x_in      (sel_x),
        .b_in      (sel_b),
        .in_valid  (accept),
        .in_id     (grant_id),
        .advance   (advance),
        .y_out     (pipe_y),
        .sat_out   (pipe_sat),
        .out_valid (pipe_valid),
        .out_id    (pipe_id)
    );

    // Outputs read as idle for the whole time reset is held, including the cycle before the reset edge.
    assign out_valid_out = pipe_valid & ~rst_in;
    assign out_y_out     = rst_in ? '0 : pipe_y;
    assign out_id_out    = rst_in ? '0 : pipe_id;
    assign out_sat_out   = pipe_sat & ~rst_in;

endmodule

// File: tb/tb_macc_arbiter.sv
// Randomized bench for macc_arbiter against a transaction-level reference model.
module tb_macc_arbiter;

    localparam int N = 4;
    localparam int W = 16;
    localparam int F = 8;
    localparam int L = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    logic [N-1:0][W-1:0]  req_m;
    logic [N-1:0][W-1:0]  req_x;
    logic [N-1:0][W-1:0]  req_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [W-1:0]         out_y;
    logic [1:0]           out_id;
    logic                 out_sat;

    int cmp_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        bit         v;
        int         id;
        logic [W-1:0] y;
        bit         s;
    } slot_t;

    slot_t pq[$];
    int    last_g;

    always #5 clk = ~clk;

    macc_arbiter #(.N_REQ(N), .WIDTH(W), .FRAC(F), .MACC_LAT(L)) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .req_valid_in  (req_valid),
        .req_ready_out (req_ready),
        .req_m_in      (req_m),
        .req_x_in      (req_x),
        .req_b_in      (req_b),
        .out_valid_out (out_valid),
        .out_ready_in  (out_ready),
        .out_y_out     (out_y),
        .out_id_out    (out_id),
        .out_sat_out   (out_sat)
    );

    function automatic void check(input string name, input longint act, input longint exp);
        cmp_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference arithmetic: exact product, floor division by 2^F, add, then clamp.
    function automatic void macc_ref(input logic [W-1:0] m, input logic [W-1:0] x,
                                     input logic [W-1:0] b,
                                     output logic [W-1:0] y, output bit s);
        longint p, q, sum, d;
        d = longint'(1) << F;
        p = longint'($signed(m)) * longint'($signed(x));
        if (p >= 0) q = p / d;
        else        q = -((-p + d - 1) / d);
        sum = q + longint'($signed(b));
        s = 1'b1;
        if (sum > 32767)       y = 16'h7FFF;
        else if (sum < -32768) y = 16'h8000;
        else begin
            y = sum[W-1:0];
            s = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        slot_t e;
        e = '{v: 1'b0, id: 0, y: '0, s: 1'b0};
        pq = {};
        for (int k = 0; k < L; k++) pq.push_front(e);
        last_g = N - 1;
    endfunction

    // Per-cycle compare, then predict what the coming rising edge does.
    always @(negedge clk) begin
        slot_t        tail;
        slot_t        e;
        logic [N-1:0] exp_rdy;
        logic [1:0]   ci;
        logic [1:0]   gi;
        bit           adv;
        bit           found;
        tail    = pq[L-1];
        adv     = !tail.v || out_ready;
        found   = 1'b0;
        gi      = '0;
        ci      = '0;
        exp_rdy = '0;
        if (!rst && adv) begin
            for (int k = 1; k <= N; k++) begin
                ci = 2'((last_g + k) % N);
                if (!found && req_valid[ci]) begin
                    found = 1'b1;
                    gi    = ci;
                end
            end
        end
        if (found) exp_rdy[gi] = 1'b1;
        check("req_ready", req_ready, exp_rdy);
        check("out_valid", out_valid, (!rst && tail.v));
        if (rst) begin
            check("out_y_rst", out_y, 0);
            check("out_id_rst", out_id, 0);
            check("out_sat_rst", out_sat, 0);
        end else if (tail.v) begin
            check("out_y", out_y, tail.y);
            check("out_id", out_id, tail.id);
            check("out_sat", out_sat, tail.s);
        end
        if (rst) begin
            model_reset();
        end else if (adv) begin
            e = '{v: 1'b0, id: 0, y: '0, s: 1'b0};
            if (found) begin
                e.v = 1'b1;
                e.id = int'(gi);
                macc_ref(req_m[gi], req_x[gi], req_b[gi], e.y, e.s);
                last_g = int'(gi);
            end
            pq.push_front(e);
            void'(pq.pop_back());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            default: return W'($urandom);
        endcase
    endfunction

    // One isolated request from requester r, with a literal expected result.
    task automatic single(input logic [1:0] r, input logic [W-1:0] m, input logic [W-1:0] x,
                          input logic [W-1:0] b, input logic [W-1:0] ey, input bit es);
        out_ready = 1'b1;
        req_m[r] = m;
        req_x[r] = x;
        req_b[r] = b;
        req_valid = '0;
        req_valid[r] = 1'b1;
        @(negedge clk);
        check("single_ready", req_ready, 4'(1) << r);
        step();
        req_valid = '0;
        check("single_lat_early", out_valid, 0);
        step();
        check("single_valid", out_valid, 1);
        check("single_y", out_y, ey);
        check("single_id", out_id, r);
        check("single_sat", out_sat, es);
        step();
        step();
    endtask

    initial begin
        logic [W-1:0] ry;
        bit           rs;
        rst = 1'b1;
        req_valid = '0;
        req_m = '0;
        req_x = '0;
        req_b = '0;
        out_ready = 1'b1;
        model_reset();
        step();
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_ready", req_ready, 0);
        check("rst_out_y", out_y, 0);
        rst = 1'b0;

        // Pin the reference arithmetic with hand-computed values.
        macc_ref(16'h0200, 16'h0180, 16'h0100, ry, rs);
        check("ref_basic", {rs, ry}, {1'b0, 16'h0400});
        macc_ref(16'hFFFF, 16'h0001, 16'h0000, ry, rs);
        check("ref_floor", {rs, ry}, {1'b0, 16'hFFFF});
        macc_ref(16'h7FFF, 16'h7FFF, 16'h7FFF, ry, rs);
        check("ref_sat_hi", {rs, ry}, {1'b1, 16'h7FFF});
        macc_ref(16'h8000, 16'h7FFF, 16'h8000, ry, rs);
        check("ref_sat_lo", {rs, ry}, {1'b1, 16'h8000});

        // Directed single-requester cases.
        single(2'd1, 16'h0200, 16'h0180, 16'h0100, 16'h0400, 1'b0);
        single(2'd0, 16'hFF00, 16'h0081, 16'h0000, 16'hFF7F, 1'b0);
        single(2'd3, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0);
        single(2'd2, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1);
        single(2'd1, 16'h8000, 16'h7FFF, 16'h8000, 16'h8000, 1'b1);

        // All requesters valid: ids rotate 0,1,2,3 with one result per cycle.
        do_reset();
        req_m = {rnd_op(), rnd_op(), rnd_op(), rnd_op()};
        req_x = {rnd_op(), rnd_op(), rnd_op(), rnd_op()};
        req_b = {rnd_op(), rnd_op(), rnd_op(), rnd_op()};
        req_valid = 4'hF;
        out_ready = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k >= 2) begin
                check("rr_valid", out_valid, 1);
                check("rr_id", out_id, (k - 2) % N);
            end
        end

        // Stall with a full pipe: nothing accepted, output holds.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_ready", req_ready, 0);
            check("stall_valid", out_valid, 1);
            step();
        end
        out_ready = 1'b1;
        step();
        step();
        req_valid = '0;
        step();
        step();
        step();

        // Requester 2 just granted, 0 and 2 both valid: 0 wins.
        do_reset();
        req_valid = 4'b0100;
        step();
        req_valid = 4'b0101;
        @(negedge clk);
        check("rr_skip", req_ready, 4'b0001);
        step();
        req_valid = '0;
        step();
        step();

        // Reset with two results in flight.
        do_reset();
        req_valid = 4'b0011;
        step();
        step();
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_valid", out_valid, 0);
        req_valid = 4'hF;
        @(negedge clk);
        check("midrst_first_grant", req_ready, 4'b0001);
        step();
        req_valid = '0;
        for (int k = 0; k < 4; k++) step();

        // Random traffic with random stalls and occasional resets.
        for (int c = 0; c < 800; c++) begin
            req_valid = N'($urandom);
            req_m = {rnd_op(), rnd_op(), rnd_op(), rnd_op()};
            req_x = {rnd_op(), rnd_op(), rnd_op(), rnd_op()};
            req_b = {rnd_op(), rnd_op(), rnd_op(), rnd_op()};
            out_ready = ($urandom_range(0, 9) < 6);
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        req_valid = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", cmp_cnt);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/macc_arbiter.md
MACC_ARBITER -- requirements
Module: macc_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, is the number of requesters sharing the MACC (2..8).
REQ-002 Parameter WIDTH, default 16, is the signed fixed-point word width of m, x, b and y.
REQ-003 Parameter FRAC, default 8, is the number of fractional bits; all operands and the result use the same Q format.
REQ-004 Parameter MACC_LAT, default 2, is the pipeline depth in cycles from accept to result (1..4).
REQ-005 clk_in  input  1  the single clock; all state updates on the rising edge.
REQ-006 rst_in  input  1  synchronous reset, active-high.
REQ-007 req_valid_in  input  N_REQ  per-requester operand-valid.
REQ-008 req_ready_out  output  N_REQ  per-requester accept strobe (one-hot or zero).
REQ-009 req_m_in, req_x_in, req_b_in  input  N_REQ x WIDTH  per-requester signed operands.
REQ-010 out_valid_out  output  1  result valid.
REQ-011 out_ready_in  input  1  downstream accepts the result.
REQ-012 out_y_out  output  WIDTH  result y = m*x + b.
REQ-013 out_id_out  output  clog2(N_REQ)  index of the requester that owns the result.
REQ-014 out_sat_out  output  1  result was saturated.

Function
REQ-015 The block shall be a single shared MACC pipeline of MACC_LAT stages, each holding {valid, id, data}.
REQ-016 advance = !out_valid_out || out_ready_in; when advance is 0, every stage shall hold its contents and no request shall be accepted.
REQ-017 When advance is 1, the block shall grant exactly one requester with req_valid_in set, chosen round-robin starting at (last_grant+1) mod N_REQ; req_ready_out shall be one-hot on that index.
REQ-018 req_ready_out shall be combinational from req_valid_in, last_grant and advance, and shall be 0 for every requester with req_valid_in low.
REQ-019 A transfer occurs when req_valid_in[i] and req_ready_out[i] are both high; last_grant shall update to i on that edge only.
REQ-020 With no valid requester and advance high, a bubble (valid=0) shall enter stage 1 and last_grant shall hold.
REQ-021 When not stalled, a request accepted at edge t shall appear on out_* with out_valid_out=1 after edge t+MACC_LAT-1 (visible for the first time in cycle t+MACC_LAT).
REQ-022 Sustained throughput shall be one result per cycle while out_ready_in is high and any requester is valid.
REQ-023 Product shall be the full 2*WIDTH signed m*x, arithmetically shifted right by FRAC (floor rounding toward minus infinity).
REQ-024 Sum shall be the shifted product plus sign-extended b, computed at 2*WIDTH+1 bits without overflow.
REQ-025 y shall saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1], and out_sat_out shall be 1 exactly when clamping occurred.
REQ-026 out_y_out, out_id_out and out_sat_out shall be stable while out_valid_out=1 and out_ready_in=0.
REQ-027 A result shall never be dropped or duplicated across any stall pattern.
REQ-028 When the final stage is empty, advance shall be 1 even if out_ready_in=0, so that pipeline bubbles collapse.

Reset
REQ-029 While rst_in is high: all stage valids shall be 0, out_valid_out=0, out_y_out=0, out_id_out=0, out_sat_out=0, and req_ready_out=0.
REQ-030 Reset shall set last_grant=N_REQ-1 so requester 0 has first priority.
REQ-031 Reset asserted mid-operation shall discard all in-flight results; the first grant after deassertion shall follow REQ-030.

Structure
REQ-032 Package macc_pkg shall hold the Q-format saturation bounds and the stage record typedef {valid, id, y, sat}; the width-dependent bounds shall be expressed as functions of WIDTH.
REQ-033 The arithmetic shall live in one sub-module, macc_pipe (m, x, b, in_valid, in_id, advance -> y, sat, out_valid, out_id); macc_arbiter shall contain only the arbiter, handshake and last_grant state.

Verification (WIDTH=16, FRAC=8, MACC_LAT=2, N_REQ=4)
REQ-034 Req 1 only: m=0x0200, x=0x0180, b=0x0100 -> y=0x0400, id=1, sat=0, out_valid two cycles after accept.
REQ-035 Sign/floor: m=0xFF00, x=0x0081, b=0x0000 -> y=0xFF7F, and m=0x7FFF, x=0x7FFF, b=0x7FFF -> y=0x7FFF with sat=1; m=0x8000, x=0x7FFF, b=0x8000 -> y=0x8000 with sat=1.
REQ-036 All four requesters valid continuously with out_ready_in=1 -> grants and out_id sequence 0,1,2,3,0,1..., one result per cycle.
REQ-037 out_ready_in low for 5 cycles with a full pipeline -> outputs frozen, req_ready_out all 0, and after release every operand set emerges exactly once and in order.
REQ-038 Requesters 0 and 2 valid, with requester 2 just granted -> the next grant goes to 0, not 2.
REQ-039 rst_in pulsed for one cycle with two results in flight -> out_valid_out=0 on the next cycle, no stale result appears afterwards, and the first grant goes to requester 0.
